// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the arbiter state type used by the bus arbiter slice.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HBURST_SINGLE = 2'b00;
    localparam logic [1:0] HBURST_INCR   = 2'b01;
    localparam logic [1:0] HBURST_INCR4  = 2'b10;
    localparam logic [1:0] HBURST_INCR8  = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester at or after the start pointer wins.
module ahb_rr_pick #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [MW-1:0] idx,
    output logic          vld
);

    int unsigned k;
    logic [MW-1:0] kk;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        k   = 0;
        kk  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // Modulo on the full-width sum keeps non-power-of-2 N from producing indices >= N.
            k  = (32'(start) + i) % N;
            kk = MW'(k);
            if (!vld && req[kk]) begin
                vld     = 1'b1;
                gnt[kk] = 1'b1;
                idx     = kk;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Multi-master AHB arbiter: round-robin grant, held across locked sequences and fixed bursts.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = $clog2(NUM_MASTERS),
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   i_hclk,
    input  logic                   i_hreset_n,
    input  logic [NUM_MASTERS-1:0] i_hbusreq,
    input  logic [NUM_MASTERS-1:0] i_hlock,
    input  logic [1:0]             i_htrans,
    input  logic [1:0]             i_hburst,
    input  logic                   i_hready,
    input  logic [1:0]             i_hresp,
    output logic [NUM_MASTERS-1:0] o_hgrant,
    output logic [MW-1:0]          o_hmaster,
    output logic [MW-1:0]          o_hmaster_data,
    output logic                   o_hmastlock
);

    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [MW-1:0] PTR_RST = MW'((DEFAULT_MASTER + 1) % NUM_MASTERS);
    localparam logic [MW-1:0] LAST_IDX = MW'(NUM_MASTERS - 1);

    arb_state_e state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [MW-1:0] ptr;
    logic [MW-1:0] gidx;
    logic lock_own;
    logic resp_abort;
    logic grant_upd;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [MW-1:0] pick_idx;
    logic pick_vld;

    ahb_rr_pick #(
        .N  (NUM_MASTERS),
        .MW (MW)
    ) u_pick (
        .req   (i_hbusreq),
        .start (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (o_hgrant[i]) gidx = MW'(i);
        end
    end

    assign lock_own   = i_hlock[gidx];
    assign resp_abort = !i_hready && (i_hresp != HRESP_OKAY) && (state != ST_LOCKED);

    always_comb begin
        cnt_n = cnt;
        if (i_hready) begin
            if (i_htrans == HTRANS_NONSEQ) begin
                case (i_hburst)
                    HBURST_INCR4: cnt_n = 3'd3;
                    HBURST_INCR8: cnt_n = 3'd7;
                    default:      cnt_n = 3'd0;
                endcase
            end else if (i_htrans == HTRANS_SEQ && cnt != 3'd0) begin
                cnt_n = cnt - 3'd1;
            end
        end

        // Lock has priority over a burst load; an error response aborts any unlocked burst.
        if (lock_own)          state_n = ST_LOCKED;
        else if (cnt_n != '0)  state_n = ST_BURST;
        else                   state_n = ST_ARB;

        if (resp_abort) begin
            cnt_n   = '0;
            state_n = ST_ARB;
        end
    end

    // Re-arbitrate only when the bus stays free across this edge, so a burst or lock
    // starting now keeps its owner.
    assign grant_upd = i_hready && (state == ST_ARB) && (state_n == ST_ARB);

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state <= ST_ARB;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            o_hgrant       <= DEF_GNT;
            ptr            <= PTR_RST;
            o_hmaster      <= DEF_IDX;
            o_hmaster_data <= DEF_IDX;
            o_hmastlock    <= 1'b0;
        end else begin
            if (grant_upd) begin
                if (pick_vld) begin
                    o_hgrant <= pick_gnt;
                    ptr      <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                end else begin
                    o_hgrant <= DEF_GNT;
                    ptr      <= PTR_RST;
                end
            end
            if (i_hready) begin
                o_hmaster      <= gidx;
                o_hmaster_data <= o_hmaster;
                o_hmastlock    <= lock_own;
            end
        end
    end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Multi-master AHB bus arbiter that shares one AHB bus between up to NUM_MASTERS instances of the team's AHB master.
- Collects each master's bus request and lock, and drives a one-hot grant back to the masters.
- Tracks the address-phase owner and the data-phase owner so the top level can mux address/control and write data.
- Holds grant for locked sequences and for fixed-length bursts; otherwise re-arbitrates round-robin.

Parameters:
- NUM_MASTERS, 4: number of requesters, 2..16.
- MW, $clog2(NUM_MASTERS): width of the master index.
- DEFAULT_MASTER, 0: master granted when nobody requests.

Ports:
- i_hclk  in  1  bus clock.
- i_hreset_n  in  1  asynchronous active-low reset.
- i_hbusreq  in  NUM_MASTERS  per-master bus request.
- i_hlock  in  NUM_MASTERS  per-master lock request.
- i_htrans  in  2  muxed HTRANS of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- i_hburst  in  2  muxed HBURST (00 SINGLE, 01 INCR, 10 INCR4, 11 INCR8).
- i_hready  in  1  bus HREADY.
- i_hresp  in  2  slave response (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT).
- o_hgrant  out  NUM_MASTERS  one-hot grant, registered.
- o_hmaster  out  MW  address-phase owner index.
- o_hmaster_data  out  MW  data-phase owner index, used for the HWDATA/HRDATA steering.
- o_hmastlock  out  1  current address-phase transfer is locked.

Behaviour:
- Reset values:
  - o_hgrant = one-hot(DEFAULT_MASTER).
  - o_hmaster = o_hmaster_data = DEFAULT_MASTER.
  - o_hmastlock = 0.
  - beat counter = 0; RR pointer = DEFAULT_MASTER+1 mod N.
- State machine, updates on rising edges only:
  - ARB: re-arbitration permitted.
  - BURST: beat counter != 0, grant frozen.
  - LOCKED: owner's i_hlock high, grant frozen.
- Beat counter:
  - Loads when i_hready=1 and i_htrans=NONSEQ: INCR4 loads 3, INCR8 loads 7, SINGLE/INCR load 0.
  - Decrements when i_hready=1 and i_htrans=SEQ, saturating at 0.
  - BUSY and IDLE leave it unchanged.
- Transitions:
  - ARB -> LOCKED when the granted master has i_hlock=1.
  - ARB -> BURST when the counter loads nonzero.
  - BURST -> ARB when the counter reaches 0, unless the owner's lock is high.
  - LOCKED -> ARB/BURST when the lock drops, according to the counter.
- Grant update: only in ARB and only when i_hready=1.
  - Round-robin search starts at the RR pointer; first requester wins.
  - The current owner keeps the grant only if no other master requests.
  - No requesters: grant returns to DEFAULT_MASTER.
  - RR pointer becomes winner+1 mod N.
- Grant latency: a request present at edge k appears on o_hgrant at edge k+1 (ARB, i_hready=1).
- Ownership pipeline:
  - o_hmaster <= index(o_hgrant) on each edge with i_hready=1.
  - o_hmaster_data <= o_hmaster on each edge with i_hready=1.
  - i_hready=0 freezes both.
- o_hmastlock <= i_hlock[index(o_hgrant)], sampled when o_hmaster updates.
- Responses:
  - ERROR, RETRY or SPLIT with i_hready=0 (first response cycle) clears the beat counter and forces ARB, unless LOCKED.
  - The new grant is taken on the second response cycle (i_hready=1).
- Simultaneous events:
  - A lock request and a counter load on the same edge: LOCKED wins.
  - A request dropped mid-BURST does not release the grant before the counter hits 0.
- Reset asserted mid-burst: everything returns to reset values asynchronously; no transfer completion is implied.
- o_hgrant is always exactly one-hot, including with NUM_MASTERS not a power of 2; indices >= N are never produced.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HBURST_SINGLE/INCR/INCR4/INCR8.
  - HRESP_OKAY/ERROR/RETRY/SPLIT.
  - The arbiter state enum.
- Sub-module ahb_rr_pick: combinational round-robin picker.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot winner, winner index, any-valid.
- The state machine, counter and ownership pipeline stay in ahb_arbiter.

Test Plan:
1. Reset, no requests -> o_hgrant=0001, o_hmaster=0, o_hmaster_data=0, o_hmastlock=0.
2. i_hbusreq=0110 held, i_hready=1, SINGLE NONSEQ each cycle -> grants alternate 0010, 0100, 0010; o_hmaster follows one cycle later; o_hmaster_data two cycles later.
3. Master 1 issues INCR4 (NONSEQ+3 SEQ) while master 2 requests, with i_hready=0 on beat 2 -> grant stays 0010 for all 4 accepted beats; moves to 0100 on the edge after the last SEQ.
4. Master 3 asserts i_hlock with three SINGLE transfers, others requesting -> grant held at 1000; o_hmastlock=1 for those address phases; released on the first edge after i_hlock drops.
5. RETRY during master 1 INCR8 beat 3 (i_hready=0 then 1) -> counter cleared; grant passes to next requester 0100 on the second response cycle.
6. Async reset pulse mid-INCR8 -> outputs return to reset values immediately, without waiting for a clock edge; arbitration restarts from pointer 1.
